// File: rtl/traffic_light_monitor.sv
`timescale 1ns/1ps
// Traffic light monitor: decodes observed lamp drives into phases, measures how long
// each phase lasts and flags illegal lamp combinations, bad sequencing and timing faults.
module traffic_light_monitor #(
  parameter int unsigned Y_DWELL    = 501,
  parameter int unsigned G_DWELL    = 1501,
  parameter int unsigned BLINK_HALF = 251,
  parameter int unsigned TOL        = 2
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        main_R,
  input  logic        main_G,
  input  logic        main_Y,
  input  logic        side_R,
  input  logic        side_G,
  input  logic        side_Y,
  output logic [2:0]  phase,
  output logic [15:0] dwell_last,
  output logic        blink_mode,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        fault_pulse,
  output logic [7:0]  fault_count
);

  typedef enum logic [2:0] {
    PH_RESET    = 3'd0,
    PH_MR_SY    = 3'd1,
    PH_MR_SG    = 3'd2,
    PH_MY_SR    = 3'd3,
    PH_MG_SR    = 3'd4,
    PH_BLINK_ON = 3'd5,
    PH_DARK     = 3'd6,
    PH_ILLEGAL  = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    FC_NONE           = 3'd0,
    FC_ILLEGAL_COMBO  = 3'd1,
    FC_BAD_TRANSITION = 3'd2,
    FC_SHORT_DWELL    = 3'd3,
    FC_LONG_DWELL     = 3'd4
  } fault_code_t;

  logic [5:0]  lamp_q;
  logic        lamp_valid;
  phase_t      phase_q, phase_d, new_phase;
  logic [15:0] dwell_cnt, dwell_cnt_d, dwell_last_d;
  logic        first_q, first_d, blink_d;
  logic        fault_d, fault_pulse_d;
  logic [2:0]  fault_code_d;
  logic [7:0]  fault_count_d;
  logic        ev_illegal, ev_bad, ev_short, ev_long, checked, fault_event;
  logic [31:0] long_limit;
  fault_code_t event_code;

  function automatic phase_t decode(input logic [5:0] l);
    // Bit order: main_R, main_G, main_Y, side_R, side_G, side_Y.
    case (l)
      6'b100_001: decode = PH_MR_SY;
      6'b100_010: decode = PH_MR_SG;
      6'b001_100: decode = PH_MY_SR;
      6'b010_100: decode = PH_MG_SR;
      6'b001_001: decode = PH_BLINK_ON;
      6'b000_000: decode = PH_DARK;
      default:    decode = PH_ILLEGAL;
    endcase
  endfunction

  function automatic logic [31:0] expected_dwell(input phase_t p);
    case (p)
      PH_MR_SY, PH_MY_SR:   expected_dwell = Y_DWELL;
      PH_MR_SG, PH_MG_SR:   expected_dwell = G_DWELL;
      PH_BLINK_ON, PH_DARK: expected_dwell = BLINK_HALF;
      default:              expected_dwell = '0;
    endcase
  endfunction

  function automatic logic legal_move(input phase_t from, input phase_t to);
    logic to_blink;
    to_blink = (to == PH_BLINK_ON) || (to == PH_DARK);
    case (from)
      PH_MR_SY:    legal_move = (to == PH_MR_SG) || to_blink;
      PH_MR_SG:    legal_move = (to == PH_MY_SR) || to_blink;
      PH_MY_SR:    legal_move = (to == PH_MG_SR) || to_blink;
      PH_MG_SR:    legal_move = (to == PH_MR_SY) || to_blink;
      PH_BLINK_ON: legal_move = (to == PH_DARK);
      PH_DARK:     legal_move = (to == PH_BLINK_ON);
      default:     legal_move = 1'b1;
    endcase
  endfunction

  assign phase = phase_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    new_phase     = decode(lamp_q);
    phase_d       = phase_q;
    dwell_cnt_d   = dwell_cnt;
    dwell_last_d  = dwell_last;
    first_d       = first_q;
    blink_d       = blink_mode;
    ev_illegal    = 1'b0;
    ev_bad        = 1'b0;
    ev_short      = 1'b0;
    ev_long       = 1'b0;
    checked       = 1'b0;
    long_limit    = expected_dwell(phase_q) + TOL + 32'd1;

    // Phase stays at 0 until the lamp register holds a real sample.
    if (lamp_valid) begin
      if (new_phase != phase_q) begin
        phase_d      = new_phase;
        dwell_cnt_d  = 16'd1;
        dwell_last_d = dwell_cnt;
        if (phase_q != PH_RESET) first_d = 1'b0;
        if (new_phase == PH_BLINK_ON || new_phase == PH_DARK) blink_d = 1'b1;
        checked    = !first_q && (phase_q != PH_ILLEGAL);
        ev_illegal = (new_phase == PH_ILLEGAL);
        ev_bad     = checked && (new_phase != PH_ILLEGAL) && !legal_move(phase_q, new_phase);
        ev_short   = checked && (({16'd0, dwell_cnt} + TOL) < expected_dwell(phase_q));
      end else begin
        if (dwell_cnt != 16'hFFFF) dwell_cnt_d = dwell_cnt + 16'd1;
        // The inequality on the old count keeps a saturated counter from refiring.
        ev_long = (phase_q != PH_RESET) && (phase_q != PH_ILLEGAL) &&
                  ({16'd0, dwell_cnt_d} == long_limit) && ({16'd0, dwell_cnt} != long_limit);
      end
    end

    fault_event = ev_illegal | ev_bad | ev_short | ev_long;
    if (ev_illegal)    event_code = FC_ILLEGAL_COMBO;
    else if (ev_bad)   event_code = FC_BAD_TRANSITION;
    else if (ev_short) event_code = FC_SHORT_DWELL;
    else if (ev_long)  event_code = FC_LONG_DWELL;
    else               event_code = FC_NONE;

    fault_pulse_d = fault_event;
    fault_d       = fault | fault_event;
    fault_code_d  = (fault_event && !fault) ? event_code : fault_code;
    fault_count_d = (fault_event && fault_count != 8'hFF) ? fault_count + 8'd1 : fault_count;
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      lamp_q      <= '0;
      lamp_valid  <= 1'b0;
      phase_q     <= PH_RESET;
      dwell_cnt   <= '0;
      dwell_last  <= '0;
      first_q     <= 1'b1;
      blink_mode  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      fault_pulse <= 1'b0;
      fault_count <= '0;
    end else begin
      lamp_q      <= {main_R, main_G, main_Y, side_R, side_G, side_Y};
      lamp_valid  <= 1'b1;
      phase_q     <= phase_d;
      dwell_cnt   <= dwell_cnt_d;
      dwell_last  <= dwell_last_d;
      first_q     <= first_d;
      blink_mode  <= blink_d;
      fault       <= fault_d;
      fault_code  <= fault_code_d;
      fault_pulse <= fault_pulse_d;
      fault_count <= fault_count_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
`timescale 1ns/1ps
// Bench for traffic_light_monitor: directed scenarios with literal expectations plus
// randomized phase sequences, all compared every cycle against a run-length phase model.
module tb_traffic_light_monitor;

  localparam int Y_DWELL    = 501;
  localparam int G_DWELL    = 1501;
  localparam int BLINK_HALF = 251;
  localparam int TOL        = 2;

  logic        clk_50, reset;
  logic        main_R, main_G, main_Y, side_R, side_G, side_Y;
  logic [2:0]  phase;
  logic [15:0] dwell_last;
  logic        blink_mode, fault, fault_pulse;
  logic [2:0]  fault_code;
  logic [7:0]  fault_count;

  traffic_light_monitor dut (
    .clk_50(clk_50), .reset(reset),
    .main_R(main_R), .main_G(main_G), .main_Y(main_Y),
    .side_R(side_R), .side_G(side_G), .side_Y(side_Y),
    .phase(phase), .dwell_last(dwell_last), .blink_mode(blink_mode),
    .fault(fault), .fault_code(fault_code), .fault_pulse(fault_pulse),
    .fault_count(fault_count)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Lamp patterns per phase code {mR,mG,mY,sR,sG,sY}; entry 7 is the illegal both-green drive.
  logic [5:0] lamp_pat [8] = '{6'b000000, 6'b100001, 6'b100010, 6'b001100,
                               6'b010100, 6'b001001, 6'b000000, 6'b010010};
  int exp_tab [8] = '{0, Y_DWELL, G_DWELL, Y_DWELL, G_DWELL, BLINK_HALF, BLINK_HALF, 0};

  function automatic int model_decode(input logic [5:0] l);
    for (int p = 1; p <= 6; p++) if (l == lamp_pat[p]) return p;
    return 7;
  endfunction

  function automatic bit model_legal(input int a, input int b);
    if (a >= 1 && a <= 4) return (b == (a % 4) + 1) || (b == 5) || (b == 6);
    if (a == 5 || a == 6) return b == 11 - a;
    return 1'b1;
  endfunction

  function automatic int next_legal(input int cur);
    if (cur >= 1 && cur <= 4) return (cur % 4) + 1;
    if (cur == 5 || cur == 6) return 11 - cur;
    return 1;
  endfunction

  // Behavioural model: phase = decode of lamps two samples back, tracked as runs.
  logic [5:0] hist [$];
  int m_phase, m_run, m_last, m_blink, m_fault, m_code, m_pulse, m_count, run_idx, code_now, nxt;
  logic       s_rst;
  logic [5:0] s_lamps;

  function automatic int pick(input int cur_code, input int c);
    return (cur_code == 0 || c < cur_code) ? c : cur_code;
  endfunction

  always @(posedge clk_50) begin
    s_rst   = reset;
    s_lamps = {main_R, main_G, main_Y, side_R, side_G, side_Y};
    if (s_rst) begin
      hist.delete();
      m_phase = 0; m_run = 0; m_last = 0; m_blink = 0;
      m_fault = 0; m_code = 0; m_pulse = 0; m_count = 0; run_idx = 0;
    end else begin
      hist.push_back(s_lamps);
      if (hist.size() > 2) void'(hist.pop_front());
      m_pulse  = 0;
      code_now = 0;
      if (hist.size() == 2) begin
        nxt = model_decode(hist[0]);
        if (nxt != m_phase) begin
          if (nxt == 7) code_now = pick(code_now, 1);
          if (run_idx >= 2 && m_phase != 7 && nxt != 7 && !model_legal(m_phase, nxt))
            code_now = pick(code_now, 2);
          if (run_idx >= 2 && m_phase != 7 && m_run < exp_tab[m_phase] - TOL)
            code_now = pick(code_now, 3);
          if (run_idx >= 1) m_last = m_run;
          m_phase = nxt;
          m_run   = 1;
          run_idx++;
          if (nxt == 5 || nxt == 6) m_blink = 1;
        end else if (m_run < 65535) begin
          m_run++;
          if (m_phase != 7 && m_run == exp_tab[m_phase] + TOL + 1) code_now = pick(code_now, 4);
        end
      end
      if (code_now != 0) begin
        m_pulse = 1;
        if (m_fault == 0) m_code = code_now;
        m_fault = 1;
        if (m_count < 255) m_count++;
      end
    end
    #1;
    check("phase", int'(phase), m_phase);
    check("dwell_last", int'(dwell_last), m_last);
    check("blink_mode", int'(blink_mode), m_blink);
    check("fault", int'(fault), m_fault);
    check("fault_code", int'(fault_code), m_code);
    check("fault_pulse", int'(fault_pulse), m_pulse);
    check("fault_count", int'(fault_count), m_count);
  end

  task automatic set_lamps(input int p);
    {main_R, main_G, main_Y, side_R, side_G, side_Y} = lamp_pat[p];
  endtask

  task automatic hold(input int p, input int n);
    set_lamps(p);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk_50);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_dwell_last"}, int'(dwell_last), 0);
    check({tag, "_blink"}, int'(blink_mode), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_code"}, int'(fault_code), 0);
    check({tag, "_pulse"}, int'(fault_pulse), 0);
    check({tag, "_count"}, int'(fault_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

  int run2, pulses, pulse_at, cur, r, dwell, tgt;

  initial begin
    reset = 1'b1;
    set_lamps(6);
    repeat (3) @(negedge clk_50);
    check_all_zero("reset");

    // Normal cycle with 2-cycle input-to-phase latency.
    reset = 1'b0;
    set_lamps(1);
    @(negedge clk_50);
    check("latency_cycle1_phase", int'(phase), 0);
    @(negedge clk_50);
    check("latency_cycle2_phase", int'(phase), 1);
    hold(1, 499);
    hold(2, G_DWELL);
    hold(3, Y_DWELL);
    hold(4, G_DWELL);
    hold(1, 10);
    check("cycle_dwell_last", int'(dwell_last), 1501);
    check("cycle_phase", int'(phase), 1);
    check("cycle_no_fault", int'(fault), 0);
    hold(1, 491);

    // One-cycle both-green glitch inside phase 2.
    hold(2, G_DWELL);
    set_lamps(7);
    @(negedge clk_50);
    set_lamps(2);
    @(negedge clk_50);
    check("glitch_phase7", int'(phase), 7);
    check("glitch_pulse", int'(fault_pulse), 1);
    check("glitch_code", int'(fault_code), 1);
    check("glitch_count", int'(fault_count), 1);
    @(negedge clk_50);
    check("glitch_phase_back", int'(phase), 2);
    check("glitch_pulse_once", int'(fault_pulse), 0);
    hold(2, 1499);

    // Bad transition 1->3, then short phase 3: first fault code stays.
    do_reset(2);
    hold(4, 50);
    hold(1, Y_DWELL);
    hold(3, 400);
    hold(4, 20);
    check("badtrans_code", int'(fault_code), 2);
    check("badtrans_count", int'(fault_count), 2);

    // Phase 2 held too long: one pulse when the dwell reaches 1504.
    do_reset(1);
    hold(1, 30);
    set_lamps(2);
    run2 = 0; pulses = 0; pulse_at = 0;
    repeat (1600) begin
      @(negedge clk_50);
      if (phase == 3'd2) run2++;
      if (fault_pulse) begin
        pulses++;
        pulse_at = run2;
      end
    end
    check("long_pulses", pulses, 1);
    check("long_pulse_at", pulse_at, 1504);
    check("long_code", int'(fault_code), 4);

    // Blink halves, then a short blink half.
    do_reset(1);
    hold(4, 20);
    for (int h = 0; h < 10; h++) hold((h % 2 == 0) ? 5 : 6, BLINK_HALF);
    check("blink_mode_set", int'(blink_mode), 1);
    check("blink_no_fault", int'(fault), 0);
    hold(5, 100);
    hold(6, 5);
    check("blink_short_code", int'(fault_code), 3);
    check("blink_short_count", int'(fault_count), 1);

    // Reset in the middle of phase 2 discards the in-progress phase.
    do_reset(1);
    hold(1, 20);
    hold(2, 200);
    reset = 1'b1;
    @(negedge clk_50);
    check_all_zero("midreset");
    reset = 1'b0;
    hold(3, Y_DWELL);
    hold(4, 30);
    check("midreset_no_fault", int'(fault), 0);
    check("midreset_phase", int'(phase), 4);

    // Randomized sequences: mostly legal with jittered dwell, plus faults and resets.
    do_reset(2);
    cur = 0;
    for (int s = 0; s < 16; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        do_reset(int'($urandom_range(1, 3)));
        cur = 0;
      end else if (r < 20) begin
        hold(7, int'($urandom_range(1, 2)));
      end else begin
        tgt = next_legal(cur);
        if (r < 30) tgt = int'($urandom_range(1, 6));
        else if (r < 40 && cur >= 1 && cur <= 4) tgt = int'($urandom_range(5, 6));
        dwell = exp_tab[tgt] + int'($urandom_range(0, 6)) - 3;
        if (r >= 40 && r < 52) dwell = int'($urandom_range(3, 400));
        if (r >= 52 && r < 62) dwell = exp_tab[tgt] + int'($urandom_range(3, 8));
        hold(tgt, dwell);
        cur = tgt;
      end
    end

    repeat (3) @(negedge clk_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter Y_DWELL, default 501, expected dwell in cycles of MR_SY and MY_SR phases.
REQ-002 Parameter G_DWELL, default 1501, expected dwell in cycles of MR_SG and MG_SR phases.
REQ-003 Parameter BLINK_HALF, default 251, expected dwell in cycles of each blink half-period.
REQ-004 Parameter TOL, default 2, allowed +/- deviation in cycles on every dwell check.
REQ-005 Port clk_50  input  1  sole clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Ports main_R, main_G, main_Y, side_R, side_G, side_Y  input  1 each  observed lamp drives.
REQ-008 Port phase  output  3  decoded current phase code.
REQ-009 Port dwell_last  output  16  length in cycles of the most recently completed phase.
REQ-010 Port blink_mode  output  1  high while phase is BLINK_ON or DARK after leaving the normal cycle.
REQ-011 Port fault  output  1  sticky fault flag.
REQ-012 Port fault_code  output  3  code of the first fault since reset.
REQ-013 Port fault_pulse  output  1  one-cycle strobe per detected fault event.
REQ-014 Port fault_count  output  8  saturating count of fault events.

Function
REQ-015 Lamps SHALL be registered once; phase SHALL be updated from the registered lamps one cycle later (2-cycle input-to-phase latency).
REQ-016 Decode: 1=MR_SY (main_R,side_Y), 2=MR_SG (main_R,side_G), 3=MY_SR (main_Y,side_R), 4=MG_SR (main_G,side_R), 5=BLINK_ON (main_Y,side_Y), 6=DARK (none lit), 7=ILLEGAL (any other pattern); 0 only in reset.
REQ-017 A 16-bit saturating dwell counter SHALL increment each cycle the decoded phase is unchanged and load 1 on a phase change.
REQ-018 On a phase change, dwell_last SHALL load the final counter value of the ending phase.
REQ-019 Legal transitions: 1->2, 2->3, 3->4, 4->1, 5<->6, any of 1..4 -> 5 or 6; all others from a phase 1..6 are BAD_TRANSITION (code 2).
REQ-020 The first phase after reset SHALL be exempt from transition and short-dwell checks.
REQ-021 Decoded 7 SHALL raise ILLEGAL_COMBO (code 1) on entry, once per contiguous ILLEGAL run; transitions into or out of 7 are not additionally checked.
REQ-022 On leaving phase p (not first, not 7), dwell < expected(p)-TOL SHALL raise SHORT_DWELL (code 3).
REQ-023 While in phase p (1..6), counter reaching expected(p)+TOL+1 SHALL raise LONG_DWELL (code 4) once for that phase.
REQ-024 Expected: Y_DWELL for 1,3; G_DWELL for 2,4; BLINK_HALF for 5,6.
REQ-025 blink_mode SHALL set on entry to 5 or 6 and clear only on reset.
REQ-026 Each fault event: fault_pulse high one cycle, fault set, fault_count +1 saturating at 255.
REQ-027 Simultaneous events in one cycle SHALL produce a single pulse and count increment; the recorded code follows priority 1>2>3>4.
REQ-028 fault_code SHALL latch only when fault is low (first fault wins).

Reset
REQ-029 Reset SHALL force phase=0, dwell counter=0, dwell_last=0, blink_mode=0, fault=0, fault_code=0, fault_pulse=0, fault_count=0, input registers=0, first-phase flag=1.
REQ-030 Reset asserted mid-phase SHALL discard all in-progress dwell and transition state with no fault reported.

Verification
REQ-031 Reset, then drive 1(501)->2(1501)->3(501)->4(1501)->1 -> no fault, dwell_last=1501 after 4 ends, phase tracks inputs with 2-cycle latency.
REQ-032 Drive main_G and side_G for 1 cycle in phase 2 -> fault_pulse once, fault_code=1, fault_count=1, phase=7 for one cycle.
REQ-033 Drive 1->3 after 501 cycles -> fault_code=2; then 3 for 400 cycles -> second pulse, fault_code stays 2, fault_count=2.
REQ-034 Hold phase 2 for 1600 cycles -> LONG_DWELL pulse exactly at dwell counter 1504, single pulse only.
REQ-035 From phase 4 enter 5/6 alternating every 251 cycles for 10 halves -> blink_mode=1, no fault; then 5 for 100 cycles -> SHORT_DWELL.
REQ-036 Assert reset for 1 cycle 200 cycles into phase 2, then drive 3 -> no fault; all outputs zero during reset cycle.
